fir_coeff_load_ctrl: RTL and testbench

//  Sequences coefficient reloads into the 4-bank FIR coefficient RAM (4 x 10 taps) of the flexible FIR top.

---
 rtl/fir_coeff_pkg.sv | 27 ++
 rtl/fir_coeff_idx_cnt.sv | 41 ++++
 rtl/fir_coeff_load_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fir_coeff_load_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared definitions for the FIR coefficient reload controller: RAM geometry,
// controller FSM encoding and the bank/offset address composition.
package fir_coeff_pkg;

  localparam int NUM_BANKS     = 4;
  localparam int TAPS_PER_BANK = 10;
  localparam int BANK_STRIDE   = 16;
  localparam int MAX_TAPS      = NUM_BANKS * TAPS_PER_BANK;
  localparam int GUARD_CYC     = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_SLOT = 3'd1,
    GET       = 3'd2,
    SETUP     = 3'd3,
    STROBE    = 3'd4,
    RECOV     = 3'd5,
    FILL      = 3'd6,
    DRAIN     = 3'd7
  } ctrlStateT;

  // Bank-strided RAM address; offsets 10..15 of each bank are never produced.
  function automatic logic [5:0] composeAddr(input logic [1:0] bank, input logic [3:0] offset);
    return 6'(int'(bank) * BANK_STRIDE + int'(offset));
  endfunction

endpackage

// File: rtl/fir_coeff_idx_cnt.sv
// Bank/offset index counter for coefficient writes. Tracks how many taps have
// been written and flags when the write now completing is the last one
// needed to reach the requested target.
module fir_coeff_idx_cnt
  import fir_coeff_pkg::*;
(
  input  logic       iClk12M,
  input  logic       iRsn,
  input  logic       clear,
  input  logic       advance,
  input  logic [5:0] target,
  output logic [5:0] addr,
  output logic       last
);

  logic [1:0] bank;
  logic [3:0] offset;
  logic [5:0] written;

  // Step through offsets 0..9 inside a bank, then move on to the next bank.
  always_ff @(posedge iClk12M) begin
    if (!iRsn || clear) begin
      bank    <= 2'd0;
      offset  <= 4'd0;
      written <= 6'd0;
    end else if (advance) begin
      written <= written + 6'd1;
      if (offset == 4'(TAPS_PER_BANK - 1)) begin
        offset <= 4'd0;
        bank   <= bank + 2'd1;
      end else begin
        offset <= offset + 4'd1;
      end
    end
  end

  assign addr = composeAddr(bank, offset);
  // Counts the write currently in flight, since advance lands one cycle later.
  assign last = (written + 6'd1) >= target;

endmodule

// File: rtl/fir_coeff_load_ctrl.sv
// Coefficient reload controller for the 4-bank FIR coefficient RAM.
// Takes linear-index coefficients from the host, writes them with a
// SETUP/STROBE/RECOV strobe sequence, and raises/lowers the coefficient
// update flag only on 600 kHz sample strobes.
// Optional build macro: COEFF_ZERO_FILL_EN -- zero-fills the taps above N
// so every load rewrites all 40 coefficients.
module fir_coeff_load_ctrl
  import fir_coeff_pkg::*;
#(
  parameter int COEF_W = 16
) (
  input  logic                     iClk12M,
  input  logic                     iRsn,
  input  logic                     iEnSample600k,
  input  logic                     iLoadReq,
  input  logic [5:0]               iNumTaps,
  input  logic                     iCoefValid,
  input  logic signed [COEF_W-1:0] iCoefData,
  output logic                     oCoefReady,
  output logic                     oCsnRam,
  output logic                     oWrnRam,
  output logic [5:0]               oAddrRam,
  output logic signed [COEF_W-1:0] oWrDtRam,
  output logic                     oCoeffUpdateFlag,
  output logic                     oBusy,
  output logic                     oDone,
  output logic                     oErr
);

  ctrlStateT  state;
  logic [5:0] numTaps;
  logic [2:0] guardCnt;
  logic [5:0] cntAddr;
  logic [5:0] cntTarget;
  logic       cntLast;

`ifdef COEFF_ZERO_FILL_EN
  logic fillPhase;
  assign cntTarget = fillPhase ? 6'(MAX_TAPS) : numTaps;
`else
  assign cntTarget = numTaps;
`endif

  assign oCoefReady = (state == GET);

  fir_coeff_idx_cnt uIdxCnt (
    .iClk12M (iClk12M),
    .iRsn    (iRsn),
    .clear   (state == IDLE),
    .advance (state == RECOV),
    .target  (cntTarget),
    .addr    (cntAddr),
    .last    (cntLast)
  );

  // Load sequencer with registered RAM strobes, flag and status pulses.
  always_ff @(posedge iClk12M) begin
    if (!iRsn) begin
      state            <= IDLE;
      numTaps          <= 6'd0;
      guardCnt         <= 3'd0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= 6'd0;
      oWrDtRam         <= '0;
      oCoeffUpdateFlag <= 1'b0;
      oBusy            <= 1'b0;
      oDone            <= 1'b0;
      oErr             <= 1'b0;
`ifdef COEFF_ZERO_FILL_EN
      fillPhase        <= 1'b0;
`endif
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (iLoadReq) begin
            if (iNumTaps > 6'(MAX_TAPS)) begin
              oErr <= 1'b1;
            end else begin
              numTaps <= iNumTaps;
              oBusy   <= 1'b1;
              state   <= WAIT_SLOT;
`ifdef COEFF_ZERO_FILL_EN
              fillPhase <= 1'b0;
`endif
            end
          end
        end
        WAIT_SLOT: begin
          if (iEnSample600k) begin
            oCoeffUpdateFlag <= 1'b1;
            guardCnt         <= 3'd0;
            if (numTaps != 6'd0) begin
              state <= GET;
            end else begin
`ifdef COEFF_ZERO_FILL_EN
              fillPhase <= 1'b1;
              state     <= FILL;
`else
              state     <= DRAIN;
`endif
            end
          end
        end
        GET: begin
          if (iCoefValid) begin
            oWrDtRam <= iCoefData;
            oAddrRam <= cntAddr;
            state    <= SETUP;
          end
        end
`ifdef COEFF_ZERO_FILL_EN
        FILL: begin
          oWrDtRam <= '0;
          oAddrRam <= cntAddr;
          state    <= SETUP;
        end
`endif
        SETUP: begin
          oCsnRam <= 1'b0;
          oWrnRam <= 1'b0;
          state   <= STROBE;
        end
        STROBE: begin
          oCsnRam <= 1'b1;
          oWrnRam <= 1'b1;
          state   <= RECOV;
        end
        RECOV: begin
          guardCnt <= 3'd0;
`ifdef COEFF_ZERO_FILL_EN
          if (!cntLast) begin
            state <= fillPhase ? FILL : GET;
          end else if (!fillPhase && numTaps != 6'(MAX_TAPS)) begin
            fillPhase <= 1'b1;
            state     <= FILL;
          end else begin
            state <= DRAIN;
          end
`else
          state <= cntLast ? DRAIN : GET;
`endif
        end
        DRAIN: begin
          if (guardCnt != 3'(GUARD_CYC)) begin
            guardCnt <= guardCnt + 3'd1;
          end else if (iEnSample600k) begin
            oCoeffUpdateFlag <= 1'b0;
            oDone            <= 1'b1;
            oBusy            <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Self-checking bench for fir_coeff_load_ctrl. Honours COEFF_ZERO_FILL_EN.
module tb_fir_coeff_load_ctrl;

`ifdef COEFF_ZERO_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic               iClk12M;
  logic               iRsn;
  logic               iEnSample600k;
  logic               iLoadReq;
  logic [5:0]         iNumTaps;
  logic               iCoefValid;
  logic signed [15:0] iCoefData;
  logic               oCoefReady;
  logic               oCsnRam;
  logic               oWrnRam;
  logic [5:0]         oAddrRam;
  logic signed [15:0] oWrDtRam;
  logic               oCoeffUpdateFlag;
  logic               oBusy;
  logic               oDone;
  logic               oErr;

  fir_coeff_load_ctrl dut (
    .iClk12M          (iClk12M),
    .iRsn             (iRsn),
    .iEnSample600k    (iEnSample600k),
    .iLoadReq         (iLoadReq),
    .iNumTaps         (iNumTaps),
    .iCoefValid       (iCoefValid),
    .iCoefData        (iCoefData),
    .oCoefReady       (oCoefReady),
    .oCsnRam          (oCsnRam),
    .oWrnRam          (oWrnRam),
    .oAddrRam         (oAddrRam),
    .oWrDtRam         (oWrDtRam),
    .oCoeffUpdateFlag (oCoeffUpdateFlag),
    .oBusy            (oBusy),
    .oDone            (oDone),
    .oErr             (oErr)
  );

  int checks   = 0;
  int failures = 0;

  logic signed [15:0] hostVals [40];
  logic [5:0]         wrAddr [$];
  logic [15:0]        wrData [$];
  int doneCnt = 0, errCnt = 0, strobeCnt = 0, flagHighCyc = 0;
  int negCyc = 0, lastStrobeCyc = -100;
  logic prevFlag = 1'b0, prevSample = 1'b0, prevRsn = 1'b0;
  int sCnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    iClk12M = 1'b0;
    forever #5 iClk12M = ~iClk12M;
  end

  // 600 kHz strobe: one cycle high every 20 clocks.
  initial begin
    iEnSample600k = 1'b0;
    forever begin
      @(posedge iClk12M);
      #1;
      sCnt = (sCnt == 19) ? 0 : sCnt + 1;
      iEnSample600k = (sCnt == 0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Bus monitor: records RAM writes and checks flag/strobe/done timing rules.
  always @(negedge iClk12M) begin
    negCyc++;
    if (oCsnRam === 1'b0 && oWrnRam === 1'b0) begin
      wrAddr.push_back(oAddrRam);
      wrData.push_back(oWrDtRam);
      strobeCnt++;
      chk("flag_during_write", {31'b0, oCoeffUpdateFlag}, 32'd1);
      chk("write_period_ge4", {31'b0, (negCyc - lastStrobeCyc) >= 4}, 32'd1);
      lastStrobeCyc = negCyc;
    end
    if (prevRsn && oCoeffUpdateFlag !== prevFlag)
      chk("flag_toggle_on_sample", {31'b0, prevSample}, 32'd1);
    if (oDone === 1'b1) begin
      doneCnt++;
      chk("busy_low_at_done", {31'b0, oBusy}, 32'd0);
    end
    if (oErr === 1'b1) errCnt++;
    if (oCoeffUpdateFlag === 1'b1) flagHighCyc++;
    prevFlag   = oCoeffUpdateFlag;
    prevSample = iEnSample600k;
    prevRsn    = iRsn;
  end

  function automatic int expAddr(input int i);
    return (i / 10) * 16 + (i % 10);
  endfunction

  // mode 0: valid held high, 1: valid pattern 1-0-0-1, 2: random valid.
  task automatic run_load(input int n, input int mode, input int extraAt, input bit align);
    int idx = 0;
    int cyc = 0;
    int done0 = doneCnt;
    bit v;
    wrAddr.delete();
    wrData.delete();
    @(negedge iClk12M);
    if (align)
      for (int k = 0; k < 25 && !iEnSample600k; k++) @(negedge iClk12M);
    iLoadReq = 1'b1;
    iNumTaps = 6'(n);
    @(negedge iClk12M);
    iLoadReq = 1'b0;
    if (align) begin
      repeat (3) @(negedge iClk12M);
      chk("req_strobe_not_used_flag", {31'b0, oCoeffUpdateFlag}, 32'd0);
      chk("req_strobe_not_used_ready", {31'b0, oCoefReady}, 32'd0);
    end
    while (doneCnt == done0 && cyc < 1000) begin
      cyc++;
      if (cyc == extraAt) begin
        iLoadReq = 1'b1;
        iNumTaps = 6'd7;
      end else begin
        iLoadReq = 1'b0;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      iCoefValid = v;
      iCoefData  = (v && idx < n) ? hostVals[idx] : 16'($urandom);
      if (oCoefReady && iCoefValid) idx++;
      @(negedge iClk12M);
    end
    iCoefValid = 1'b0;
    iLoadReq   = 1'b0;
    chk("done_pulse_count", 32'(doneCnt - done0), 32'd1);
    chk("host_words_taken", 32'(idx), 32'(n));
    repeat (2) @(negedge iClk12M);
    chk("busy_after_done", {31'b0, oBusy}, 32'd0);
    chk("flag_after_done", {31'b0, oCoeffUpdateFlag}, 32'd0);
  endtask

  task automatic verify_writes(input int n, input string tag);
    int expCnt = FILL_EN ? 40 : n;
    logic [15:0] expD;
    chk({tag, "_write_count"}, 32'(wrAddr.size()), 32'(expCnt));
    for (int i = 0; i < expCnt && i < wrAddr.size(); i++) begin
      expD = (i < n) ? hostVals[i] : 16'h0000;
      chk($sformatf("%s_addr%0d", tag, i), {26'b0, wrAddr[i]}, 32'(expAddr(i)));
      chk($sformatf("%s_data%0d", tag, i), {16'b0, wrData[i]}, {16'b0, expD});
    end
  endtask

  logic signed [15:0] kaiser [17];
  int e0, s0, f0, d0, n;

  initial begin
    kaiser = '{16'sd146, 16'sd0, -16'sd242, 16'sd0, 16'sd427, 16'sd0, -16'sd723, 16'sd0,
               16'sd1187, 16'sd0, -16'sd1932, 16'sd0, 16'sd3274, 16'sd0, -16'sd6356,
               16'sd20783, 16'sd21845};
    iRsn = 1'b0;
    iLoadReq = 1'b0;
    iNumTaps = 6'd0;
    iCoefValid = 1'b0;
    iCoefData = 16'sd0;

    // Reset values.
    repeat (5) @(posedge iClk12M);
    @(negedge iClk12M);
    chk("rst_csn", {31'b0, oCsnRam}, 32'd1);
    chk("rst_wrn", {31'b0, oWrnRam}, 32'd1);
    chk("rst_flag", {31'b0, oCoeffUpdateFlag}, 32'd0);
    chk("rst_busy", {31'b0, oBusy}, 32'd0);
    chk("rst_done", {31'b0, oDone}, 32'd0);
    chk("rst_err", {31'b0, oErr}, 32'd0);
    chk("rst_ready", {31'b0, oCoefReady}, 32'd0);
    chk("rst_addr", {26'b0, oAddrRam}, 32'd0);
    chk("rst_data", {16'b0, oWrDtRam}, 32'd0);
    @(posedge iClk12M);
    #1 iRsn = 1'b1;

    // Full 40-tap load, values i+1, valid held high.
    for (int i = 0; i < 40; i++) hostVals[i] = 16'(i + 1);
    run_load(40, 0, 0, 1'b0);
    verify_writes(40, "full");

    // 33-tap symmetric set; the tail lands in bank 3.
    for (int i = 0; i < 40; i++) hostVals[i] = 16'($urandom);
    for (int i = 0; i < 17; i++) begin
      hostVals[i]      = kaiser[i];
      hostVals[32 - i] = kaiser[i];
    end
    run_load(33, 0, 0, 1'b0);
    verify_writes(33, "kaiser");

    // Backpressure, request issued together with a sample strobe.
    for (int i = 0; i < 40; i++) hostVals[i] = 16'($urandom);
    run_load(3, 1, 0, 1'b1);
    verify_writes(3, "bp");

    // Oversized request is rejected.
    e0 = errCnt; s0 = strobeCnt; f0 = flagHighCyc;
    @(negedge iClk12M);
    iLoadReq = 1'b1;
    iNumTaps = 6'd41;
    @(negedge iClk12M);
    iLoadReq = 1'b0;
    repeat (30) @(negedge iClk12M);
    chk("err_pulse_count", 32'(errCnt - e0), 32'd1);
    chk("err_no_strobes", 32'(strobeCnt - s0), 32'd0);
    chk("err_flag_stays_low", 32'(flagHighCyc - f0), 32'd0);
    chk("err_not_busy", {31'b0, oBusy}, 32'd0);

    // Second request while busy is ignored.
    e0 = errCnt;
    for (int i = 0; i < 40; i++) hostVals[i] = 16'($urandom);
    run_load(5, 0, 30, 1'b0);
    verify_writes(5, "collide");
    s0 = strobeCnt; d0 = doneCnt;
    repeat (60) @(negedge iClk12M);
    chk("collide_no_extra_strobes", 32'(strobeCnt - s0), 32'd0);
    chk("collide_no_extra_done", 32'(doneCnt - d0), 32'd0);
    chk("collide_no_err", 32'(errCnt - e0), 32'd0);

    // Zero-tap load: flag still spans a full sample period.
    f0 = flagHighCyc;
    run_load(0, 0, 0, 1'b0);
    verify_writes(0, "n0");
    chk("n0_flag_span", {31'b0, (flagHighCyc - f0) >= 20}, 32'd1);

    // Random lengths, data and valid pattern.
    repeat (3) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < 40; i++) hostVals[i] = 16'($urandom);
      run_load(n, 2, 0, 1'b0);
      verify_writes(n, "rand");
    end

    // Reset in the middle of a load aborts it without oDone.
    d0 = doneCnt;
    @(negedge iClk12M);
    iLoadReq = 1'b1;
    iNumTaps = 6'd40;
    iCoefValid = 1'b1;
    iCoefData = 16'sh1234;
    @(negedge iClk12M);
    iLoadReq = 1'b0;
    repeat (50) @(negedge iClk12M);
    chk("midload_busy", {31'b0, oBusy}, 32'd1);
    @(posedge iClk12M);
    #1 iRsn = 1'b0;
    repeat (5) @(posedge iClk12M);
    @(negedge iClk12M);
    chk("midrst_csn", {31'b0, oCsnRam}, 32'd1);
    chk("midrst_wrn", {31'b0, oWrnRam}, 32'd1);
    chk("midrst_flag", {31'b0, oCoeffUpdateFlag}, 32'd0);
    chk("midrst_busy", {31'b0, oBusy}, 32'd0);
    @(posedge iClk12M);
    #1 iRsn = 1'b1;
    iCoefValid = 1'b0;
    repeat (60) @(negedge iClk12M);
    chk("midrst_no_done", 32'(doneCnt - d0), 32'd0);
    chk("midrst_idle_busy", {31'b0, oBusy}, 32'd0);
    chk("midrst_idle_flag", {31'b0, oCoeffUpdateFlag}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
